// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: feeder FSM states and default widths.
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_LINES_DEF = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    DRAIN = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/mac_feeder.sv
// Streams one frame of samples into the MAC signal FIFO, waits for the MAC result
// (or a timeout), then holds the result until the downstream consumer takes it.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_LINES     = ADDR_LINES_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  wr_en_o,
  output logic                  last_o,
  input  logic                  full_i,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] result_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_err_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam int CW = ADDR_LINES + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_LINES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [TW-1:0]   tcnt;
  logic            in_feed;
  logic            xfer;
  logic            force_last;

  // Gating with rstn_i keeps the handshake outputs quiet while reset is held.
  assign in_feed    = (state == IDLE) || (state == SEND);
  assign s_ready_o  = rstn_i & ((in_feed & ~full_i) | (state == DRAIN));
  assign xfer       = s_valid_i & s_ready_o;
  assign wr_en_o    = xfer & in_feed;
  assign count_nxt  = count + 1'b1;
  assign force_last = wr_en_o & ~s_last_i & (count_nxt == DEPTH);
  assign last_o     = wr_en_o & (s_last_i | force_last);
  assign signal_o   = s_data_i;
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      count      <= '0;
      tcnt       <= '0;
      m_data_o   <= '0;
      m_valid_o  <= 1'b0;
      m_err_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      // The timeout counter only runs in WAIT, so it is already zero on entry.
      if (state != WAIT) tcnt <= '0;
      case (state)
        IDLE, SEND: begin
          if (wr_en_o) begin
            count <= count_nxt;
            if (s_last_i) begin
              state <= WAIT;
            end else if (force_last) begin
              overflow_o <= 1'b1;
              state      <= DRAIN;
            end else begin
              state <= SEND;
            end
          end
        end
        DRAIN: begin
          if (xfer && s_last_i) state <= WAIT;
        end
        WAIT: begin
          if (done_i) begin
            m_data_o  <= result_i;
            m_err_o   <= 1'b0;
            m_valid_o <= 1'b1;
            state     <= OUT;
          end else if (tcnt == TLAST) begin
            m_data_o  <= '0;
            m_err_o   <= 1'b1;
            m_valid_o <= 1'b1;
            state     <= OUT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        OUT: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Scoreboard bench for mac_feeder: the driver queues expected FIFO writes and results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mac_feeder;
  import mac_pkg::*;

  localparam int DW    = 32;
  localparam int AL    = 5;
  localparam int TO    = 16;
  localparam int DEPTH = 2 ** AL;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [DW-1:0] signal;
  logic          wr_en;
  logic          last;
  logic          full = 1'b0;
  logic          done = 1'b0;
  logic [DW-1:0] result = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_err;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          overflow;

  always #5 clk = ~clk;

  mac_feeder #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
    .signal_o(signal), .wr_en_o(wr_en), .last_o(last), .full_i(full),
    .done_i(done), .result_i(result),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_err_o(m_err), .m_ready_i(m_ready),
    .busy_o(busy), .overflow_o(overflow)
  );

  typedef struct { logic [DW-1:0] d; logic l; } wr_t;
  typedef struct { logic [DW-1:0] d; logic e; } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_ovf  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Monitor: FIFO writes, result handshakes, and hold-stability of a stalled result.
  logic          pv = 1'b0, pr = 1'b0, pe = 1'b0;
  logic [DW-1:0] pd = '0;
  wr_t           mw;
  res_t          mr;
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
    end else begin
      if (wr_en) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mw = exp_wr.pop_front();
          chk("wr_data", signal, mw.d);
          chk("wr_last", last, mw.l);
        end
      end else if (last) begin
        chk("last_without_wr", last, 0);
      end
      if (pv && !pr) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_err", m_err, pe);
      end
      if (m_valid && m_ready) begin
        if (exp_res.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          mr = exp_res.pop_front();
          chk("res_data", m_data, mr.d);
          chk("res_err", m_err, mr.e);
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pe = m_err;
    end
  end

  // Drive one frame; the expected FIFO image follows from depth truncation rules.
  task automatic send_frame(input int len, input bit seq, input bit stall);
    bit acc;
    for (int i = 1; i <= len; i++) begin
      wr_t w;
      s_data  = seq ? DW'(i) : DW'($urandom);
      s_last  = (i == len);
      s_valid = 1'b1;
      if (i <= DEPTH) begin
        w.d = s_data;
        w.l = (i == len) || (i == DEPTH && len > DEPTH);
        exp_wr.push_back(w);
      end
      if (len > DEPTH) exp_ovf = 1'b1;
      if (stall && i == len / 2 + 1) begin
        full = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_ready", s_ready, 0);
          chk("stall_wr", wr_en, 0);
          adv();
        end
      end
      acc = 1'b0;
      for (int n = 0; n < 200 && !acc; n++) begin
        full   = (seq || stall) ? 1'b0 : ($urandom % 4 == 0);
        done   = ($urandom % 6 == 0);
        result = $urandom;
        @(negedge clk);
        acc = s_ready;
        adv();
      end
      if (!acc) chk("send_timeout", 0, 1);
    end
    s_valid = 1'b0; s_last = 1'b0; full = 1'b0; done = 1'b0;
  endtask

  // Called in WAIT cycle 0. D<=TO-1 means done_i arrives in WAIT; otherwise timeout.
  task automatic mac_response(input int d, input logic [DW-1:0] res);
    res_t r;
    s_valid = 1'b1; s_data = $urandom;
    chk("wait_busy", busy, 1);
    chk("wait_ready", s_ready, 0);
    if (d <= TO - 1) begin
      r.d = res; r.e = 1'b0; exp_res.push_back(r);
      repeat (d) adv();
      done = 1'b1; result = res;
      adv();
      done = 1'b0; result = $urandom;
      chk("done_latency", m_valid, 1);
    end else begin
      r.d = '0; r.e = 1'b1; exp_res.push_back(r);
      repeat (TO - 1) adv();
      chk("pre_timeout_valid", m_valid, 0);
      adv();
      chk("timeout_valid", m_valid, 1);
      chk("timeout_err", m_err, 1);
      chk("timeout_data", m_data, 0);
      chk("out_ready", s_ready, 0);
      done = 1'b1; result = $urandom;
      adv();
      done = 1'b0;
      repeat (d - TO) adv();
    end
    s_valid = 1'b0;
  endtask

  task automatic consume(input int hold);
    bit hs;
    m_ready = 1'b0;
    repeat (hold) adv();
    hs = 1'b0;
    for (int n = 0; n < 100 && !hs; n++) begin
      m_ready = (hold > 0) ? 1'b1 : ($urandom % 3 == 0);
      @(negedge clk);
      hs = m_valid && m_ready;
      adv();
    end
    m_ready = 1'b0;
    if (!hs) chk("handshake_timeout", 0, 1);
    chk("idle_after_hs", busy, 0);
    chk("overflow_flag", overflow, exp_ovf);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    s_valid = 1'b0;
    rstn = 1'b1;
    adv();

    // Four-sample frame, result 0xAA ten cycles into WAIT
    send_frame(4, 1'b1, 1'b0);
    mac_response(10, 32'h0000_00AA);
    consume(0);

    // One-sample frame goes straight to WAIT
    send_frame(1, 1'b0, 1'b0);
    chk("single_busy", busy, 1);
    mac_response(3, DW'($urandom));
    consume(0);

    // Back-pressure from the MAC FIFO mid-frame
    send_frame(8, 1'b0, 1'b1);
    mac_response(5, DW'($urandom));
    consume(1);

    // Oversized frame: truncation at depth, tail drained
    chk("ovf_before", overflow, 0);
    send_frame(40, 1'b0, 1'b0);
    chk("ovf_after_40", overflow, 1);
    chk("ovf_busy", busy, 1);
    mac_response(7, DW'($urandom));
    consume(0);

    // Timeout with the consumer stalling for five cycles
    send_frame(5, 1'b0, 1'b0);
    mac_response(TO + 2, DW'($urandom));
    consume(5);

    for (int f = 0; f < 30; f++) begin
      send_frame($urandom_range(1, 45), 1'b0, 1'b0);
      mac_response($urandom_range(0, 20), DW'($urandom));
      consume($urandom_range(0, 3));
    end

    // Reset while waiting for the MAC drops the frame and sticky overflow
    send_frame(6, 1'b0, 1'b0);
    repeat (3) adv();
    s_valid = 1'b1; full = 1'b0;
    rstn = 1'b0;
    #1;
    exp_ovf = 1'b0;
    chk("wrst_m_valid", m_valid, 0);
    chk("wrst_m_err", m_err, 0);
    chk("wrst_m_data", m_data, 0);
    chk("wrst_busy", busy, 0);
    chk("wrst_overflow", overflow, 0);
    chk("wrst_ready", s_ready, 0);
    chk("wrst_wr_en", wr_en, 0);
    chk("wrst_last", last, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    adv();
    send_frame(3, 1'b1, 1'b0);
    mac_response(2, 32'h1234_5678);
    consume(0);

    repeat (3) adv();
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, sample/result width; ADDR_LINES, default 5, MAC FIFO depth 2**ADDR_LINES; TIMEOUT_CYCLES, default 1024, max WAIT cycles.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
s_data_i  in  DATA_WIDTH  upstream sample
s_valid_i  in  1  upstream sample valid
s_last_i  in  1  final sample of frame
s_ready_o  out  1  sample accepted this cycle if s_valid_i
signal_o  out  DATA_WIDTH  sample to MAC signal FIFO
wr_en_o  out  1  MAC FIFO write strobe
last_o  out  1  MAC frame-end/start strobe
full_i  in  1  MAC FIFO full
done_i  in  1  MAC result ready pulse
result_i  in  DATA_WIDTH  MAC result
m_data_o  out  DATA_WIDTH  registered result
m_valid_o  out  1  result valid
m_err_o  out  1  result invalid (timeout), qualified by m_valid_o
m_ready_i  in  1  downstream accepts result
busy_o  out  1  state != IDLE
overflow_o  out  1  sticky: a frame exceeded FIFO depth

Function
REQ-003 SHALL implement FSM states IDLE, SEND, DRAIN, WAIT, OUT.
REQ-004 Transfer SHALL be s_valid_i & s_ready_o; s_ready_o = (IDLE or SEND) & ~full_i, or 1 in DRAIN.
REQ-005 signal_o SHALL equal s_data_i combinationally; wr_en_o = transfer in IDLE/SEND; last_o = wr_en_o & (s_last_i | forced-last of REQ-008).
REQ-006 IDLE: first transfer with s_last_i=0 -> SEND; with s_last_i=1 -> WAIT (one-sample frame).
REQ-007 SEND: transfer with s_last_i=1 -> WAIT; count (ADDR_LINES+1 bits) SHALL increment per transfer and clear on IDLE entry.
REQ-008 When the transfer making count = 2**ADDR_LINES has s_last_i=0, last_o SHALL be forced to 1, overflow_o set, state -> DRAIN.
REQ-009 DRAIN: transfers discarded (wr_en_o=0); transfer with s_last_i=1 -> WAIT.
REQ-010 WAIT: timeout counter clears on entry, increments each cycle; done_i -> OUT with m_data_o <= result_i, m_err_o <= 0; counter reaching TIMEOUT_CYCLES-1 without done_i -> OUT with m_data_o <= 0, m_err_o <= 1.
REQ-011 Latency: done_i in WAIT at cycle N -> m_valid_o=1 at N+1 with result_i sampled at N.
REQ-012 OUT: m_valid_o=1, m_data_o/m_err_o stable until m_ready_i=1; handshake -> IDLE next cycle.
REQ-013 done_i outside WAIT SHALL be ignored; done_i and timeout in same cycle -> done_i wins.
REQ-014 s_ready_o SHALL be 0 in WAIT and OUT; full_i=1 stalls SEND without state change.
REQ-015 overflow_o SHALL clear only on reset.

Reset
REQ-016 rstn_i low SHALL asynchronously force IDLE, counters 0, m_data_o=0, m_valid_o=0, m_err_o=0, overflow_o=0, busy_o=0.
REQ-017 Reset mid-frame SHALL discard the partial frame; first post-reset transfer starts a new frame.
REQ-018 Combinational outputs SHALL be 0 while rstn_i low (s_ready_o, wr_en_o, last_o).

Structure
REQ-019 FSM state enum and default DATA_WIDTH/ADDR_LINES constants SHALL live in shared package mac_pkg.
REQ-020 SHALL be a single module, no sub-modules; instantiated alongside mac with ports wired name-for-name (signal_o->signal_i, wr_en_o->wr_en_i, last_o->last_i, full_o->full_i, done_o->done_i, result_o->result_i).

Verification
REQ-021 Frame of 4 samples 1,2,3,4 (last on 4), done_i with result_i=0x0000_00AA 10 cycles later -> 4 writes, last_o on 4th, m_valid_o next cycle with m_data_o=0xAA, m_err_o=0.
REQ-022 Single sample with s_last_i=1 in IDLE -> wr_en_o & last_o same cycle, state WAIT.
REQ-023 full_i=1 for 3 cycles mid-frame -> s_ready_o=0, no wr_en_o, count frozen; resumes on full_i=0.
REQ-024 40-sample frame, ADDR_LINES=5 -> last_o forced on sample 32, overflow_o=1, samples 33-40 discarded, state WAIT after sample 40.
REQ-025 No done_i, TIMEOUT_CYCLES=16 -> m_valid_o=1, m_err_o=1, m_data_o=0 after 16 WAIT cycles; m_ready_i held low 5 cycles -> outputs stable, IDLE after handshake.
REQ-026 rstn_i low during WAIT -> all outputs 0 immediately; new frame after release completes normally.
